// File: rtl/anim_pkg.sv
// Shared types, widths and the frame-limit rule for the animation playback path.
package anim_pkg;

  localparam int ANIM_W     = 6;
  localparam int FRAME_W    = 5;
  localparam int MAX_FRAMES = 32;

  typedef logic [ANIM_W-1:0]  anim_t;
  typedef logic [FRAME_W-1:0] frame_t;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  // A stored limit of 0 stands for the full 32-frame animation.
  function automatic logic [FRAME_W:0] eff_limit(input frame_t limit);
    if (limit == {FRAME_W{1'b0}}) begin
      eff_limit = (FRAME_W+1)'(MAX_FRAMES);
    end else begin
      eff_limit = {1'b0, limit};
    end
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running frame-rate prescaler; tick period is 2^(PRESCALE_W - speed_i) cycles.
module tick_prescaler #(
  parameter int PRESCALE_W = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       clr_i,
  input  logic [2:0] speed_i,
  output logic       tick_o
);

  logic [PRESCALE_W-1:0] count_q;
  logic [PRESCALE_W-1:0] count_d;
  logic [PRESCALE_W-1:0] term_s;

  // >= rather than == so a speed-up past the current count fires at once.
  always_comb begin
    term_s  = {PRESCALE_W{1'b1}} >> speed_i;
    tick_o  = (count_q >= term_s);
    count_d = count_q;
    if (ena) begin
      if (clr_i || tick_o) begin
        count_d = {PRESCALE_W{1'b0}};
      end else begin
        count_d = count_q + PRESCALE_W'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= {PRESCALE_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Animation/frame sequencer for the 7-segment display.
// Optional AUTO_ADVANCE_EN adds auto_i: each wrap moves on to the next animation.
module frame_sequencer
  import anim_pkg::*;
#(
  parameter int PRESCALE_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
`ifdef AUTO_ADVANCE_EN
  input  logic               auto_i,
`endif
  input  logic [ANIM_W-1:0]  anim_sel_i,
  input  logic [FRAME_W-1:0] limit_i,
  input  logic [2:0]         speed_i,
  input  logic               pause_i,
  input  logic               step_i,
  output logic [ANIM_W-1:0]  animation_o,
  output logic [FRAME_W-1:0] frame_o,
  output logic               frame_tick_o,
  output logic               wrap_o
);

  anim_t          anim_q, anim_d;
  frame_t         frame_q, frame_d;
  logic           step_q, step_d;
  logic           ftick_q, ftick_d;
  logic           wrap_q, wrap_d;
  logic           tick_s;
  logic           load_s;
  logic           advance_s;
  logic           at_end_s;
  logic [FRAME_W:0] lim_s;
  mode_e          mode_s;

`ifdef AUTO_ADVANCE_EN
  assign mode_s = auto_i ? MODE_AUTO : MODE_MANUAL;
`else
  assign mode_s = MODE_MANUAL;
`endif

  tick_prescaler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .clr_i  (load_s),
    .speed_i(speed_i),
    .tick_o (tick_s)
  );

  // Load beats advance; a dropped advance produces no pulses.
  always_comb begin
    anim_d    = anim_q;
    frame_d   = frame_q;
    step_d    = step_q;
    ftick_d   = 1'b0;
    wrap_d    = 1'b0;
    load_s    = 1'b0;
    advance_s = 1'b0;
    lim_s     = eff_limit(limit_i);
    at_end_s  = (({1'b0, frame_q} + (FRAME_W+1)'(1)) >= lim_s);
    if (ena) begin
      step_d = step_i;
      case (mode_s)
        MODE_MANUAL: load_s = (anim_sel_i != anim_q);
        MODE_AUTO:   load_s = 1'b0;
        default:     load_s = 1'b0;
      endcase
      advance_s = pause_i ? (step_i & ~step_q) : tick_s;
      if (load_s) begin
        anim_d  = anim_sel_i;
        frame_d = {FRAME_W{1'b0}};
      end else if (advance_s) begin
        ftick_d = 1'b1;
        if (at_end_s) begin
          frame_d = {FRAME_W{1'b0}};
          wrap_d  = 1'b1;
          if (mode_s == MODE_AUTO) begin
            anim_d = anim_q + ANIM_W'(1);
          end else begin
            anim_d = anim_q;
          end
        end else begin
          frame_d = frame_q + FRAME_W'(1);
        end
      end else begin
        frame_d = frame_q;
      end
    end else begin
      step_d = step_q;
    end
  end

  // Sequencer state and registered pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      anim_q  <= {ANIM_W{1'b0}};
      frame_q <= {FRAME_W{1'b0}};
      step_q  <= 1'b0;
      ftick_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      anim_q  <= anim_d;
      frame_q <= frame_d;
      step_q  <= step_d;
      ftick_q <= ftick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign animation_o  = anim_q;
  assign frame_o      = frame_q;
  assign frame_tick_o = ftick_q;
  assign wrap_o       = wrap_q;

endmodule
